// File: rtl/nway_trace_active_set.sv
// In-flight tracker for n-way trace memory operations: issues to the cache in
// allocation order, matches responses by address, retires in allocation order.
module nway_trace_active_set #(
    parameter int unsigned ENTRIES     = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 17
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           alloc_valid,
    output logic                           alloc_ready,
    input  logic [INDEX_WIDTH-1:0]         alloc_trace_index,
    input  logic [ADDR_WIDTH-1:0]          alloc_mem_addr,
    output logic                           cache_req_valid,
    input  logic                           cache_req_ready,
    output logic [ADDR_WIDTH-1:0]          cache_req_addr,
    input  logic                           cache_resp_valid,
    input  logic [ADDR_WIDTH-1:0]          cache_resp_addr,
    input  logic                           cache_resp_hit,
    output logic                           retire_valid,
    input  logic                           retire_ready,
    output logic [INDEX_WIDTH-1:0]         retire_trace_index,
    output logic [ADDR_WIDTH-1:0]          retire_mem_addr,
    output logic                           retire_hit,
    output logic [$clog2(ENTRIES+1)-1:0]   occupancy,
    output logic                           unmatched_resp
);

    localparam int unsigned PW = $clog2(ENTRIES);
    localparam int unsigned OW = $clog2(ENTRIES + 1);

    typedef enum logic [1:0] {
        FREE,
        MAKE_REQUEST,
        WAIT_FOR_PROCESSING,
        REQUEST_RETIRED
    } entry_state_t;

    entry_state_t                   state_q [ENTRIES];
    entry_state_t                   state_d [ENTRIES];
    logic [INDEX_WIDTH-1:0]         idx_q   [ENTRIES];
    logic [ADDR_WIDTH-1:0]          addr_q  [ENTRIES];
    logic                           hit_q   [ENTRIES];

    logic [PW-1:0]                  tail_q;
    logic [PW-1:0]                  issue_q;
    logic [PW-1:0]                  head_q;
    logic [OW-1:0]                  occ_q;
    logic                           unmatched_q;

    logic                           alloc_fire;
    logic                           issue_fire;
    logic                           retire_fire;
    logic                           match_found;
    logic [PW-1:0]                  match_slot;
    logic [PW-1:0]                  scan_slot;

    assign alloc_ready        = (occ_q != OW'(ENTRIES));
    assign cache_req_valid    = (state_q[issue_q] == MAKE_REQUEST);
    assign cache_req_addr     = addr_q[issue_q];
    assign retire_valid       = (state_q[head_q] == REQUEST_RETIRED);
    assign retire_trace_index = idx_q[head_q];
    assign retire_mem_addr    = addr_q[head_q];
    assign retire_hit         = hit_q[head_q];
    assign occupancy          = occ_q;
    assign unmatched_resp     = unmatched_q;

    assign alloc_fire  = alloc_valid && alloc_ready;
    assign issue_fire  = cache_req_valid && cache_req_ready;
    assign retire_fire = retire_valid && retire_ready;

    // Scan from head so the oldest waiting entry with the address wins.
    always_comb begin
        match_found = 1'b0;
        match_slot  = '0;
        scan_slot   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            scan_slot = head_q + PW'(i);
            if (cache_resp_valid && !match_found &&
                state_q[scan_slot] == WAIT_FOR_PROCESSING &&
                addr_q[scan_slot] == cache_resp_addr) begin
                match_found = 1'b1;
                match_slot  = scan_slot;
            end
        end
    end

    // All four transitions target entries in distinct pre-cycle states, so they never collide.
    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            state_d[i] = state_q[i];
        end
        if (alloc_fire)  state_d[tail_q]     = MAKE_REQUEST;
        if (issue_fire)  state_d[issue_q]    = WAIT_FOR_PROCESSING;
        if (match_found) state_d[match_slot] = REQUEST_RETIRED;
        if (retire_fire) state_d[head_q]     = FREE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                state_q[i] <= FREE;
                idx_q[i]   <= '0;
                addr_q[i]  <= '0;
                hit_q[i]   <= 1'b0;
            end
            tail_q      <= '0;
            issue_q     <= '0;
            head_q      <= '0;
            occ_q       <= '0;
            unmatched_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                state_q[i] <= state_d[i];
            end
            if (alloc_fire) begin
                idx_q[tail_q]  <= alloc_trace_index;
                addr_q[tail_q] <= alloc_mem_addr;
                hit_q[tail_q]  <= 1'b0;
                tail_q         <= tail_q + PW'(1);
            end
            if (issue_fire) begin
                issue_q <= issue_q + PW'(1);
            end
            if (match_found) begin
                hit_q[match_slot] <= cache_resp_hit;
            end
            if (cache_resp_valid && !match_found) begin
                unmatched_q <= 1'b1;
            end
            if (retire_fire) begin
                head_q <= head_q + PW'(1);
            end
            case ({alloc_fire, retire_fire})
                2'b10:   occ_q <= occ_q + OW'(1);
                2'b01:   occ_q <= occ_q - OW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_nway_trace_active_set.sv
// Bench for nway_trace_active_set: queue scoreboard of allocated entries,
// updated at each handshake and compared against DUT outputs every cycle.
module tb_nway_trace_active_set;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [16:0] alloc_trace_index;
    logic [31:0] alloc_mem_addr;
    logic        cache_req_valid;
    logic        cache_req_ready;
    logic [31:0] cache_req_addr;
    logic        cache_resp_valid;
    logic [31:0] cache_resp_addr;
    logic        cache_resp_hit;
    logic        retire_valid;
    logic        retire_ready;
    logic [16:0] retire_trace_index;
    logic [31:0] retire_mem_addr;
    logic        retire_hit;
    logic [2:0]  occupancy;
    logic        unmatched_resp;

    nway_trace_active_set #(
        .ENTRIES(4),
        .ADDR_WIDTH(32),
        .INDEX_WIDTH(17)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alloc_valid(alloc_valid),
        .alloc_ready(alloc_ready),
        .alloc_trace_index(alloc_trace_index),
        .alloc_mem_addr(alloc_mem_addr),
        .cache_req_valid(cache_req_valid),
        .cache_req_ready(cache_req_ready),
        .cache_req_addr(cache_req_addr),
        .cache_resp_valid(cache_resp_valid),
        .cache_resp_addr(cache_resp_addr),
        .cache_resp_hit(cache_resp_hit),
        .retire_valid(retire_valid),
        .retire_ready(retire_ready),
        .retire_trace_index(retire_trace_index),
        .retire_mem_addr(retire_mem_addr),
        .retire_hit(retire_hit),
        .occupancy(occupancy),
        .unmatched_resp(unmatched_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // st: 0 = awaiting issue, 1 = waiting for response, 2 = complete
    typedef struct {
        logic [16:0] idx;
        logic [31:0] addr;
        int          st;
        logic        hit;
    } ent_t;

    ent_t sb[$];
    logic unmatched_exp;
    int   n_cmp;
    int   n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    int   mon_mk;
    int   mon_m;
    logic mon_ret;
    ent_t mon_e;

    // Evaluate all handshakes on pre-edge state, then update the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            unmatched_exp = 1'b0;
        end else begin
            mon_mk = -1;
            for (int i = 0; i < sb.size(); i++)
                if (mon_mk < 0 && sb[i].st == 0) mon_mk = i;
            check("occupancy", 64'(occupancy), 64'(sb.size()));
            check("alloc_ready", 64'(alloc_ready), 64'(sb.size() != 4));
            check("req_valid", 64'(cache_req_valid), 64'(mon_mk >= 0));
            if (mon_mk >= 0) check("req_addr", 64'(cache_req_addr), 64'(sb[mon_mk].addr));
            mon_ret = (sb.size() > 0) && (sb[0].st == 2);
            check("retire_valid", 64'(retire_valid), 64'(mon_ret));
            if (mon_ret) begin
                check("retire_idx", 64'(retire_trace_index), 64'(sb[0].idx));
                check("retire_addr", 64'(retire_mem_addr), 64'(sb[0].addr));
                check("retire_hit", 64'(retire_hit), 64'(sb[0].hit));
            end
            check("unmatched", 64'(unmatched_resp), 64'(unmatched_exp));

            mon_m = -1;
            if (cache_resp_valid) begin
                for (int i = 0; i < sb.size(); i++)
                    if (mon_m < 0 && sb[i].st == 1 && sb[i].addr == cache_resp_addr) mon_m = i;
                if (mon_m >= 0) begin
                    mon_e = sb[mon_m];
                    mon_e.st = 2;
                    mon_e.hit = cache_resp_hit;
                    sb[mon_m] = mon_e;
                end else begin
                    unmatched_exp = 1'b1;
                end
            end
            if (mon_mk >= 0 && cache_req_ready) begin
                mon_e = sb[mon_mk];
                mon_e.st = 1;
                sb[mon_mk] = mon_e;
            end
            if (alloc_valid && sb.size() != 4) begin
                mon_e.idx = alloc_trace_index;
                mon_e.addr = alloc_mem_addr;
                mon_e.st = 0;
                mon_e.hit = 1'b0;
                sb.push_back(mon_e);
            end
            if (mon_ret && retire_ready) void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [16:0] idx, input logic [31:0] addr);
        alloc_valid = 1'b1;
        alloc_trace_index = idx;
        alloc_mem_addr = addr;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] addr, input logic hit);
        cache_resp_valid = 1'b1;
        cache_resp_addr = addr;
        cache_resp_hit = hit;
        tick();
        cache_resp_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        unmatched_exp = 1'b0;
        rst_n = 1'b0;
        alloc_valid = 1'b0;
        alloc_trace_index = '0;
        alloc_mem_addr = '0;
        cache_req_ready = 1'b1;
        cache_resp_valid = 1'b0;
        cache_resp_addr = '0;
        cache_resp_hit = 1'b0;
        retire_ready = 1'b1;
        tick();
        tick();
        check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check("rst_req_valid", 64'(cache_req_valid), 64'd0);
        check("rst_retire_valid", 64'(retire_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_unmatched", 64'(unmatched_resp), 64'd0);
        rst_n = 1'b1;
        tick();

        // single operation
        do_alloc(17'd5, 32'h100);
        check("single_req_latency", 64'(cache_req_valid), 64'd1);
        check("single_occ_1", 64'(occupancy), 64'd1);
        tick();
        respond(32'h100, 1'b1);
        check("single_retire_valid", 64'(retire_valid), 64'd1);
        tick();
        check("single_occ_0", 64'(occupancy), 64'd0);

        // fill with issue stalled, fifth offer held off until a retire frees a slot
        cache_req_ready = 1'b0;
        alloc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alloc_trace_index = 17'(10 + i);
            alloc_mem_addr = 32'h200 + 32'(i * 16);
            tick();
        end
        alloc_trace_index = 17'd14;
        alloc_mem_addr = 32'h240;
        tick();
        check("full_alloc_ready", 64'(alloc_ready), 64'd0);
        check("full_occupancy", 64'(occupancy), 64'd4);
        cache_req_ready = 1'b1;
        tick();
        cache_req_ready = 1'b0;
        respond(32'h200, 1'b1);
        tick();
        check("freed_alloc_ready", 64'(alloc_ready), 64'd1);
        tick();
        alloc_valid = 1'b0;
        cache_req_ready = 1'b1;
        repeat (4) tick();
        respond(32'h220, 1'b0);
        respond(32'h210, 1'b1);
        respond(32'h240, 1'b1);
        respond(32'h230, 1'b0);
        repeat (5) tick();

        // out-of-order completion
        do_alloc(17'd21, 32'h10);
        do_alloc(17'd22, 32'h20);
        do_alloc(17'd23, 32'h30);
        repeat (2) tick();
        respond(32'h30, 1'b0);
        check("ooo_head_blocked", 64'(retire_valid), 64'd0);
        respond(32'h10, 1'b1);
        respond(32'h20, 1'b1);
        repeat (4) tick();

        // duplicate addresses complete oldest first
        retire_ready = 1'b0;
        do_alloc(17'd1, 32'h40);
        do_alloc(17'd2, 32'h40);
        repeat (2) tick();
        respond(32'h40, 1'b0);
        respond(32'h40, 1'b1);
        retire_ready = 1'b1;
        repeat (3) tick();

        // unmatched response with nothing waiting
        respond(32'h999, 1'b1);
        check("unmatched_set", 64'(unmatched_resp), 64'd1);
        tick();
        check("unmatched_sticky", 64'(unmatched_resp), 64'd1);

        // pipelined stream wrapping the pointers several times
        for (int k = 0; k < 12; k++) begin
            alloc_valid = (k < 10);
            alloc_trace_index = 17'(100 + k);
            alloc_mem_addr = 32'h1000 + 32'(k * 4);
            cache_resp_valid = (k >= 2);
            cache_resp_addr = 32'h1000 + 32'((k - 2) * 4);
            cache_resp_hit = 1'($urandom_range(0, 1));
            tick();
        end
        alloc_valid = 1'b0;
        cache_resp_valid = 1'b0;
        repeat (3) tick();
        check("wrap_drained", 64'(sb.size()), 64'd0);

        // reset mid-operation with three entries outstanding
        retire_ready = 1'b0;
        do_alloc(17'd50, 32'h500);
        do_alloc(17'd51, 32'h510);
        do_alloc(17'd52, 32'h520);
        repeat (2) tick();
        respond(32'h500, 1'b1);
        check("pre_rst_retire_valid", 64'(retire_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check("mid_rst_req_valid", 64'(cache_req_valid), 64'd0);
        check("mid_rst_req_addr", 64'(cache_req_addr), 64'd0);
        check("mid_rst_retire_valid", 64'(retire_valid), 64'd0);
        check("mid_rst_retire_idx", 64'(retire_trace_index), 64'd0);
        check("mid_rst_retire_addr", 64'(retire_mem_addr), 64'd0);
        check("mid_rst_retire_hit", 64'(retire_hit), 64'd0);
        check("mid_rst_occupancy", 64'(occupancy), 64'd0);
        check("mid_rst_unmatched", 64'(unmatched_resp), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        respond(32'h510, 1'b1);
        check("stale_resp_unmatched", 64'(unmatched_resp), 64'd1);
        retire_ready = 1'b1;
        repeat (2) tick();
        check("final_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
